ex_mem_skid_stage: RTL

- EX→MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result and zero flag together with the store data, destination register and MEM/WB control bits.
- Resolves BEQ/BNE taken/not-taken from the zero flag.
- Presents everything to the data-memory stage over a valid/ready handshake, using a 2-entry skid buffer so that a memory stall never creates a combinational path back into EX.

---
 rtl/ex_mem_skid_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer; also resolves BEQ/BNE from the ALU zero flag.
// Latency: 1 cycle from accept to out_valid. Throughput is 1/cycle while out_ready stays high.
// Backpressure: in_ready = ~skid_valid comes straight from a flop, so out_ready never reaches EX combinationally.
// Optional: define EX_MEM_FWD_EN to add the fwd_valid/fwd_rd/fwd_data operand-forwarding outputs.
module ex_mem_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_branch,
    input  logic              branch_ne,
    input  logic [DATA_W-1:0] branch_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RA_W-1:0]   out_rd_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              branch_taken,
    output logic [DATA_W-1:0] out_branch_target
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] branch_target;
        logic [RA_W-1:0]   rd_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              taken;
    } entry_t;

    entry_t cap;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   send;

    // Writes to x0 and contradictory load+store are sanitised once, here, at capture.
    always_comb begin
        cap               = '0;
        cap.alu_result    = alu_result;
        cap.store_data    = store_data;
        cap.branch_target = branch_target;
        cap.rd_addr       = rd_addr;
        cap.reg_write     = reg_write & (rd_addr != '0);
        cap.mem_read      = mem_read;
        cap.mem_write     = mem_write & ~mem_read;
        cap.taken         = is_branch & (branch_ne ? ~alu_zero : alu_zero);
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign send     = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // A same-cycle send still completes on the MEM side; only held state is dropped.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (send) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || send) begin
            main_valid <= accept;
            if (accept) begin
                main_q <= cap;
            end
        end else if (accept) begin
            skid_q     <= cap;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid         = main_valid;
    assign out_alu_result    = main_q.alu_result;
    assign out_store_data    = main_q.store_data;
    assign out_rd_addr       = main_q.rd_addr;
    assign out_reg_write     = main_q.reg_write;
    assign out_mem_read      = main_q.mem_read;
    assign out_mem_write     = main_q.mem_write;
    assign out_branch_target = main_q.branch_target;
    assign branch_taken      = main_valid & main_q.taken;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = main_valid & main_q.reg_write & ~main_q.mem_read;
    assign fwd_rd    = main_valid ? main_q.rd_addr : '0;
    assign fwd_data  = main_valid ? main_q.alu_result : '0;
`endif

endmodule
